dft4_acc_seq: RTL and testbench

//  Multiplier-free 4-point DFT engine: X[k] = sum_n x[n]*W^(nk), W = -j.

---
 rtl/dft4_pkg.sv | 36 +++
 rtl/dft4_acc_lane.sv | 44 ++++
 rtl/dft4_acc_seq.sv | 133 +++++++++++++
 tb/tb_dft4_acc_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dft4_pkg.sv
// Shared types for the 4-point DFT accumulator engine: FSM states and the
// twiddle-to-add/sub mapping used by both accumulator lanes.
package dft4_pkg;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_CALC = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   // Operand source for a lane: real part (a) or imaginary part (b) of x[n]
   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

   typedef struct packed {
      logic re_src;
      logic re_sub;
      logic im_src;
      logic im_sub;
   } tw_sel_t;

   // x*(-j)^m for x = a + jb reduces to a swap and/or negation of a and b
   function automatic tw_sel_t twiddle_sel(input logic [1:0] m);
      tw_sel_t s;
      s = '{SRC_A, 1'b0, SRC_B, 1'b0};
      case (m)
         2'd0: s = '{SRC_A, 1'b0, SRC_B, 1'b0};  // re+=a, im+=b
         2'd1: s = '{SRC_B, 1'b0, SRC_A, 1'b1};  // re+=b, im-=a
         2'd2: s = '{SRC_A, 1'b1, SRC_B, 1'b1};  // re-=a, im-=b
         2'd3: s = '{SRC_B, 1'b1, SRC_A, 1'b0};  // re-=b, im+=a
         default: s = '{SRC_A, 1'b0, SRC_B, 1'b0};
      endcase
      return s;
   endfunction

endpackage

// File: rtl/dft4_acc_lane.sv
// One add/sub accumulator lane. Picks a or b, sign-extends it to the
// accumulator width and adds or subtracts it; load restarts from zero.
module dft4_acc_lane
   import dft4_pkg::*;
#(
   parameter int W_IN  = 8,
   parameter int W_ACC = W_IN + 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W_IN-1:0]  a,
   input  logic [W_IN-1:0]  b,
   input  logic             src_sel,
   input  logic             sub,
   input  logic             load,
   input  logic             en,
   output logic [W_ACC-1:0] acc
);

   logic [W_ACC-1:0] term;
   logic [W_ACC-1:0] base;
   logic [W_ACC-1:0] acc_d;
   logic [W_ACC-1:0] acc_q;

   // Select and sign-extend the term, then accumulate (or restart on load)
   always_comb begin
      term  = (src_sel == SRC_B) ? {{(W_ACC-W_IN){b[W_IN-1]}}, b}
                                 : {{(W_ACC-W_IN){a[W_IN-1]}}, a};
      base  = load ? '0 : acc_q;
      acc_d = acc_q;
      if (en) begin
         acc_d = sub ? (base - term) : (base + term);
      end
   end

   // Accumulator register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) acc_q <= '0;
      else      acc_q <= acc_d;
   end

   assign acc = acc_q;

endmodule

// File: rtl/dft4_acc_seq.sv
// Multiplier-free 4-point DFT: buffers 4 complex samples, then for each bin
// k runs 4 add/sub cycles on re/im lanes and presents X[k] until accepted.
module dft4_acc_seq
   import dft4_pkg::*;
#(
   parameter int W_IN  = 8,
   parameter int W_ACC = W_IN + 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W_IN-1:0]  in_re,
   input  logic [W_IN-1:0]  in_im,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W_ACC-1:0] out_re,
   output logic [W_ACC-1:0] out_im,
   output logic [1:0]       out_k
);

   state_t state_d, state_q;
   logic [1:0] idx_d, idx_q;
   logic [1:0] n_d, n_q;
   logic [1:0] k_d, k_q;
   logic [3:0][W_IN-1:0] samp_re_d, samp_re_q;
   logic [3:0][W_IN-1:0] samp_im_d, samp_im_q;

   logic       calc_en;
   logic [1:0] m;
   tw_sel_t    sel;

   // FSM next state, sample capture, counters and handshake outputs
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      n_d       = n_q;
      k_d       = k_q;
      samp_re_d = samp_re_q;
      samp_im_d = samp_im_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      calc_en   = 1'b0;
      case (state_q)
         ST_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               samp_re_d[idx_q] = in_re;
               samp_im_d[idx_q] = in_im;
               idx_d            = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d = ST_CALC;
                  k_d     = 2'd0;
                  n_d     = 2'd0;
               end
            end
         end
         ST_CALC: begin
            calc_en = 1'b1;
            n_d     = n_q + 2'd1;  // wraps to 0 after the last term
            if (n_q == 2'd3) state_d = ST_OUT;
         end
         ST_OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (k_q == 2'd3) begin
                  state_d = ST_LOAD;
                  idx_d   = 2'd0;
                  k_d     = 2'd0;
               end else begin
                  state_d = ST_CALC;
                  k_d     = k_q + 2'd1;
                  n_d     = 2'd0;
               end
            end
         end
         default: begin
            state_d = ST_LOAD;
            idx_d   = 2'd0;
         end
      endcase
   end

   // State, counters and sample buffer; reset drops any partial frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_LOAD;
         idx_q     <= 2'd0;
         n_q       <= 2'd0;
         k_q       <= 2'd0;
         samp_re_q <= '0;
         samp_im_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         n_q       <= n_d;
         k_q       <= k_d;
         samp_re_q <= samp_re_d;
         samp_im_q <= samp_im_d;
      end
   end

   // Twiddle exponent (n*k) mod 4 falls out of a 2-bit product
   assign m   = n_q * k_q;
   assign sel = twiddle_sel(m);

   dft4_acc_lane #(.W_IN(W_IN), .W_ACC(W_ACC)) u_lane_re (
      .clk     (clk),
      .rst     (rst),
      .a       (samp_re_q[n_q]),
      .b       (samp_im_q[n_q]),
      .src_sel (sel.re_src),
      .sub     (sel.re_sub),
      .load    (n_q == 2'd0),
      .en      (calc_en),
      .acc     (out_re)
   );

   dft4_acc_lane #(.W_IN(W_IN), .W_ACC(W_ACC)) u_lane_im (
      .clk     (clk),
      .rst     (rst),
      .a       (samp_re_q[n_q]),
      .b       (samp_im_q[n_q]),
      .src_sel (sel.im_src),
      .sub     (sel.im_sub),
      .load    (n_q == 2'd0),
      .en      (calc_en),
      .acc     (out_im)
   );

   assign out_k = k_q;

endmodule

// File: tb/tb_dft4_acc_seq.sv
// Bench for dft4_acc_seq: directed and random frames, spectrum from a
// complex-multiply reference model, random output backpressure and stalls.
module tb_dft4_acc_seq;

   localparam int W_IN  = 8;
   localparam int W_ACC = W_IN + 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W_IN-1:0]  in_re = '0;
   logic [W_IN-1:0]  in_im = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [W_ACC-1:0] out_re;
   logic [W_ACC-1:0] out_im;
   logic [1:0]       out_k;

   int total = 0;
   int bad   = 0;
   int fr_re[4];
   int fr_im[4];
   int exp_re[4];
   int exp_im[4];

   dft4_acc_seq #(.W_IN(W_IN), .W_ACC(W_ACC)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_im     (in_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im),
      .out_k     (out_k)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // X[k] = sum x[n] * W^(nk), W = -j, done as a true complex multiply
   function automatic void model();
      int wr, wi, m;
      for (int k = 0; k < 4; k++) begin
         exp_re[k] = 0;
         exp_im[k] = 0;
         for (int n = 0; n < 4; n++) begin
            m  = (n * k) % 4;
            wr = (m == 0) ? 1 : ((m == 2) ? -1 : 0);
            wi = (m == 1) ? -1 : ((m == 3) ? 1 : 0);
            exp_re[k] += fr_re[n] * wr - fr_im[n] * wi;
            exp_im[k] += fr_re[n] * wi + fr_im[n] * wr;
         end
      end
   endfunction

   task automatic set_frame(input int r0, input int i0, input int r1, input int i1,
                            input int r2, input int i2, input int r3, input int i3);
      fr_re[0] = r0; fr_im[0] = i0;
      fr_re[1] = r1; fr_im[1] = i1;
      fr_re[2] = r2; fr_im[2] = i2;
      fr_re[3] = r3; fr_im[3] = i3;
   endtask

   task automatic rand_frame();
      for (int n = 0; n < 4; n++) begin
         fr_re[n] = int'($urandom_range(0, 255)) - 128;
         fr_im[n] = int'($urandom_range(0, 255)) - 128;
      end
   endtask

   // Push the first cnt samples of the frame with random idle gaps
   task automatic send(input int cnt);
      int i;
      int cyc;
      i   = 0;
      cyc = 0;
      while (i < cnt && cyc < 400) begin
         @(negedge clk);
         cyc++;
         check("in_ready_load", int'(in_ready), 1);
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_re    = W_IN'($urandom);
            in_im    = W_IN'($urandom);
         end else begin
            in_valid = 1'b1;
            in_re    = fr_re[i][W_IN-1:0];
            in_im    = fr_im[i][W_IN-1:0];
            if (in_ready) i++;
         end
      end
      if (i < cnt) check("send_timeout", i, cnt);
   endtask

   // Drain the 4 bins; every cycle with out_valid must show the current bin.
   // Garbage in_valid during compute/output must be ignored.
   task automatic collect(input string name, input int bp_bin, input int bp_len, input bit fast);
      int got;
      int cyc;
      int hold;
      int first;
      got   = 0;
      cyc   = 0;
      hold  = 0;
      first = -1;
      model();
      while (got < 4 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         check({name, ":in_ready_busy"}, int'(in_ready), 0);
         if (out_valid) begin
            if (first < 0) begin
               first = cyc;
               check({name, ":latency"}, first, 5);
            end
            check({name, ":out_k"}, int'(out_k), got);
            check({name, ":out_re"}, int'($signed(out_re)), exp_re[got]);
            check({name, ":out_im"}, int'($signed(out_im)), exp_im[got]);
            if (got == bp_bin && hold < bp_len) begin
               out_ready = 1'b0;
               hold++;
            end else begin
               out_ready = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
            end
            if (out_ready) got++;
         end else begin
            out_ready = 1'($urandom_range(0, 1));
         end
         in_valid = 1'($urandom_range(0, 1));
         in_re    = W_IN'($urandom);
         in_im    = W_IN'($urandom);
      end
      if (got < 4) check({name, ":timeout"}, got, 4);
      if (bp_bin >= 0) check({name, ":bp_cycles"}, hold, bp_len);
   endtask

   task automatic frame(input string name, input int bp_bin, input int bp_len, input bit fast);
      send(4);
      collect(name, bp_bin, bp_len, fast);
   endtask

   initial begin
      #1;
      check("rst:out_valid", int'(out_valid), 0);
      check("rst:in_ready", int'(in_ready), 1);
      check("rst:out_k", int'(out_k), 0);
      check("rst:out_re", int'($signed(out_re)), 0);
      @(negedge clk);
      rst = 1'b1;

      set_frame(1, 0, 0, 0, 0, 0, 0, 0);
      frame("impulse", -1, 0, 1'b1);
      set_frame(1, 0, 1, 0, 1, 0, 1, 0);
      frame("dc", -1, 0, 1'b0);
      set_frame(0, 0, 1, 0, 0, 0, 0, 0);
      frame("delayed", -1, 0, 1'b0);
      set_frame(-128, -128, -128, -128, -128, -128, -128, -128);
      frame("neg_full", -1, 0, 1'b0);
      set_frame(127, 0, 0, 127, -128, 0, 0, -128);
      frame("x1_peak", -1, 0, 1'b0);
      set_frame(127, 0, 0, -128, -128, 0, 0, 127);
      frame("mixed_ext", -1, 0, 1'b0);

      rand_frame();
      frame("backpressure", 1, 7, 1'b1);

      // Abandon a frame after 2 samples; reset must drop them
      rand_frame();
      send(2);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b0;
      #1;
      check("midrst:out_valid", int'(out_valid), 0);
      check("midrst:in_ready", int'(in_ready), 1);
      check("midrst:out_k", int'(out_k), 0);
      @(negedge clk);
      rst = 1'b1;
      rand_frame();
      frame("after_rst", -1, 0, 1'b0);

      for (int f = 0; f < 6; f++) begin
         rand_frame();
         frame("random", int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), 1'b0);
      end

      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
